// File: rtl/data_memory_ctrl.sv
// Byte-addressed big-endian data memory controller with byte/half/word access.
// Latency: 1 cycle from request acceptance to the Valid pulse, for loads, stores and errors.
// Backpressure: Ready is low during the post-reset clear sweep; requests seen while Ready=0 are ignored.
//
// Ports:
//   CLK, Reset            clock, synchronous active-low reset
//   Req, WE, Size,        request strobe, store/load, 00=byte 01=half 10=word 11=reserved,
//   Unsigned              zero-extend (1) or sign-extend (0) on sub-word loads
//   Daddr, DataIn         byte address, right-aligned store data
//   Ready                 controller idle and accepting requests
//   Valid, Err, DataOut   one-cycle completion pulse, rejection flag, load result
module data_memory_ctrl #(
    parameter int DEPTH      = 64,
    parameter bit INIT_CLEAR = 1'b1
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        Req,
    input  logic        WE,
    input  logic [1:0]  Size,
    input  logic        Unsigned,
    input  logic [31:0] Daddr,
    input  logic [31:0] DataIn,
    output logic        Ready,
    output logic        Valid,
    output logic [31:0] DataOut,
    output logic        Err
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic {
        S_INIT = 1'b0,
        S_IDLE = 1'b1
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic           w_sweep_we;
    logic [AW-1:0]  r_ptr;
    logic           r_ready;
    logic           r_valid;
    logic           r_err;
    logic [31:0]    r_dout;

    logic [7:0]     r_mem [DEPTH];

    logic           w_accept;
    logic [2:0]     w_nbytes;
    logic [32:0]    w_end;
    logic           w_err;
    logic [AW-1:0]  w_base;
    logic [AW-1:0]  w_ridx [4];
    logic [7:0]     w_rb   [4];
    logic [31:0]    w_load;
    logic           w_sign;
    logic [3:0]     w_we;
    logic [AW-1:0]  w_widx [4];
    logic [7:0]     w_wdat [4];

    // ---------------- FSM ----------------
    always_ff @(posedge CLK) begin
        if (!Reset) begin
            r_state <= INIT_CLEAR ? S_INIT : S_IDLE;
            r_ptr   <= '0;
            r_ready <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_sweep_we) begin
                r_ptr <= r_ptr + AW'(4);
            end
            // Registered so Ready stays low through reset even when the sweep is skipped.
            r_ready <= (w_state_nxt == S_IDLE);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_sweep_we  = 1'b0;
        case (r_state)
            S_INIT: begin
                w_sweep_we = 1'b1;
                if (r_ptr == AW'(DEPTH - 4)) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_IDLE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ---------------- request decode ----------------
    assign w_accept = Req && r_ready;
    assign w_base   = Daddr[AW-1:0];

    always_comb begin
        case (Size)
            2'b00:   w_nbytes = 3'd1;
            2'b01:   w_nbytes = 3'd2;
            default: w_nbytes = 3'd4;
        endcase
        // 33-bit sum so addresses near 2^32 cannot wrap back into range.
        w_end = {1'b0, Daddr} + 33'(w_nbytes);
        w_err = (Size == 2'b11)
             || ((Size == 2'b01) && Daddr[0])
             || ((Size == 2'b10) && (Daddr[1:0] != 2'b00))
             || (w_end > 33'(DEPTH));
    end

    // ---------------- read path ----------------
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            w_ridx[k] = w_base + AW'(k);
            w_rb[k]   = r_mem[w_ridx[k]];
        end
        w_sign = 1'b0;
        w_load = '0;
        case (Size)
            2'b00: begin
                w_sign = !Unsigned && w_rb[0][7];
                w_load = {{24{w_sign}}, w_rb[0]};
            end
            2'b01: begin
                w_sign = !Unsigned && w_rb[0][7];
                w_load = {{16{w_sign}}, w_rb[0], w_rb[1]};
            end
            default: w_load = {w_rb[0], w_rb[1], w_rb[2], w_rb[3]};
        endcase
    end

    // ---------------- write path ----------------
    // Lane k writes address base+k; the sweep and stores never overlap because
    // stores need Ready, which is only high in IDLE.
    always_comb begin
        w_we = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            w_widx[k] = (w_sweep_we ? r_ptr : w_base) + AW'(k);
            w_wdat[k] = 8'h00;
        end
        if (w_sweep_we) begin
            w_we = 4'b1111;
        end else if (w_accept && WE && !w_err) begin
            case (Size)
                2'b00: begin
                    w_we      = 4'b0001;
                    w_wdat[0] = DataIn[7:0];
                end
                2'b01: begin
                    w_we      = 4'b0011;
                    w_wdat[0] = DataIn[15:8];
                    w_wdat[1] = DataIn[7:0];
                end
                default: begin
                    w_we      = 4'b1111;
                    w_wdat[0] = DataIn[31:24];
                    w_wdat[1] = DataIn[23:16];
                    w_wdat[2] = DataIn[15:8];
                    w_wdat[3] = DataIn[7:0];
                end
            endcase
        end
    end

    // Array itself is not reset; only writes are blocked while Reset is low.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            for (int k = 0; k < 4; k++) begin
                if (w_we[k]) begin
                    r_mem[w_widx[k]] <= w_wdat[k];
                end
            end
        end
    end

    // ---------------- response ----------------
    always_ff @(posedge CLK) begin
        if (!Reset) begin
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            r_dout  <= '0;
        end else if (w_accept) begin
            r_valid <= 1'b1;
            r_err   <= w_err;
            r_dout  <= (!WE && !w_err) ? w_load : 32'h0;
        end else begin
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            r_dout  <= '0;
        end
    end

    assign Ready   = r_ready;
    assign Valid   = r_valid;
    assign Err     = r_err;
    assign DataOut = r_dout;

endmodule

// File: doc/data_memory_ctrl.md
Name: data_memory_ctrl

Overview:
- Parametrised successor to the single-cycle byte-addressed data memory. Adds byte, halfword and word access with sign/zero extension, a registered read with a valid handshake, alignment and range checking, and a post-reset clear sweep.
- Sits between the MEM-stage load/store unit and the RAM array.
- Storage is big-endian: the byte at Daddr is the MSB of a word.

Parameters:
- DEPTH, 64, memory size in bytes; must be a multiple of 4.
- INIT_CLEAR, 1, 1 = zero the whole array after reset before accepting requests; 0 = skip the sweep (contents undefined).

Ports:
- CLK  input  1  clock; all state updates on posedge.
- Reset  input  1  synchronous, active-low reset.
- Req  input  1  request strobe; sampled only when Ready=1.
- WE  input  1  1 = store, 0 = load.
- Size  input  2  00 = byte, 01 = halfword, 10 = word, 11 = reserved.
- Unsigned  input  1  load extension: 1 = zero-extend, 0 = sign-extend; ignored for word access and stores.
- Daddr  input  32  byte address.
- DataIn  input  32  store data, right-aligned (byte uses [7:0], half uses [15:0]).
- Ready  output  1  block is in IDLE and can accept a request.
- Valid  output  1  one-cycle completion pulse for each accepted request.
- DataOut  output  32  load result, valid when Valid=1; 0 otherwise.
- Err  output  1  qualifies Valid; request was rejected.

Behaviour:
- Reset: while Reset=0 at a posedge:
  - State becomes INIT (INIT_CLEAR=1) or IDLE (INIT_CLEAR=0).
  - Sweep pointer clears to 0.
  - Outputs: Ready=0, Valid=0, Err=0, DataOut=0.
  - Reset mid-sweep or mid-request aborts it; a pending Valid is dropped and the sweep restarts from address 0.
- INIT state:
  - Each cycle writes 0 to bytes ptr..ptr+3; ptr advances by 4.
  - After the write at ptr = DEPTH-4, the next state is IDLE.
  - The sweep takes DEPTH/4 cycles; Ready rises the cycle after the last clear write.
  - Req is ignored while Ready=0: no Valid and no memory change.
- IDLE state:
  - Ready=1 continuously.
  - A request is accepted on a posedge where Req=1 and Ready=1.
  - Back-to-back requests every cycle are supported.
- Error check, evaluated at acceptance:
  - Size=11.
  - Misaligned: half with Daddr[0]=1, or word with Daddr[1:0]!=0.
  - Out of range: Daddr + bytes > DEPTH, computed at 33-bit width with no wrap-around.
  - On any error: no memory write; the next cycle gives Valid=1, Err=1, DataOut=0.
- Store:
  - Bytes are written at the acceptance edge.
  - Byte: RAM[a]=DataIn[7:0].
  - Half: RAM[a]=DataIn[15:8], RAM[a+1]=DataIn[7:0].
  - Word: RAM[a..a+3]=DataIn[31:24..7:0].
  - Next cycle: Valid=1, Err=0, DataOut=0.
- Load:
  - Data is read at acceptance and registered.
  - Next cycle: Valid=1, Err=0, DataOut = extended value.
  - Byte: {24{sign}, RAM[a]}.
  - Half: {16{sign}, RAM[a], RAM[a+1]}.
  - Word: {RAM[a], RAM[a+1], RAM[a+2], RAM[a+3]}.
  - sign = Unsigned ? 0 : MSB of the loaded field.
- Latency: exactly 1 cycle from acceptance to Valid for all request types.
- Valid, Err and DataOut return to 0 the cycle after a pulse unless a new request was accepted.
- Ordering: a load accepted the cycle after a store to overlapping bytes returns the new data. No bypass is needed because the write commits before the load samples.
- Only the addressed bytes change on a store; neighbouring bytes are preserved.

Test Plan:
- Reset held low 2 cycles, then released, with DEPTH=64, INIT_CLEAR=1 → Ready=0 for exactly 16 cycles, then 1. A word load at 0x3C returns 0x00000000, Valid=1, Err=0.
- Word store 0x8081_7F01 at 0x10, then byte loads at 0x10/0x13 with Unsigned=0 → DataOut=0xFFFFFF80, then 0x00000001. A half load at 0x10 with Unsigned=1 → 0x00008081.
- Byte store 0xAA at 0x12 after the above, then word load at 0x10 → 0x8081AA01. Store followed by load on consecutive cycles → Valid on both cycles, load returns updated data.
- Word load at 0x06 → Valid=1, Err=1, DataOut=0. Half store at 0x3F → Err=1 and a word load at 0x3C shows unchanged data. Word at 0x40 → Err=1. Size=11 → Err=1.
- Reset asserted at sweep cycle 5 after junk was stored (INIT_CLEAR=1) → sweep restarts, Ready is low a full 16 cycles, and all locations read 0 afterwards.
- Req=1 while Ready=0 during the sweep → no Valid pulse and no write; with INIT_CLEAR=0, Ready=1 the first cycle after Reset is released.
